// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: PC sequencer for a combinational instruction ROM with a
// 2-entry fetch buffer toward IF/ID, branch redirect and illegal-address stop.
// Optional build macro IMEM_FETCH_PERF_EN adds saturating fetch/stall counters.
module imem_fetch_ctrl #(
  parameter int unsigned MEM_SIZE = 1024,
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        br_valid,
  input  logic [63:0] br_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc,
  output logic        fault
`ifdef IMEM_FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetches,
  output logic [31:0] perf_stalls
`endif
);

  localparam int unsigned PC_W    = 64;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned CNT_W   = 2;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  typedef enum logic [0:0] {RUN = 1'b0, FAULT = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic                fault_q, fault_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  fetch_entry_t [1:0]  buf_q, buf_d;

  logic                legal_c;
  logic                pop_c;
  logic                fetch_en_c;
  logic [CNT_W-1:0]    wr_pos_c;

  // Address legality (no wrap: widen before adding) and handshake terms
  always_comb begin
    legal_c    = (pc_q[1:0] == 2'b00) &&
                 (({1'b0, pc_q} + 65'd3) < 65'(MEM_SIZE));
    out_valid  = (cnt_q != 2'd0) & ~br_valid;
    pop_c      = out_valid & out_ready;
    fetch_en_c = (state_q == RUN) & legal_c & ~br_valid &
                 ((cnt_q < 2'd2) | pop_c);
    wr_pos_c   = cnt_q - CNT_W'(pop_c);
  end

  assign imem_addr = pc_q;
  assign out_pc    = buf_q[0].pc;
  assign out_instr = buf_q[0].instr;
  assign fault     = fault_q;

  // State register with PC and sticky fault flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  // Next state: redirect wins over fault entry and sequential fetch
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    if (br_valid) begin
      state_d = RUN;
      pc_d    = br_target;
      fault_d = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (!legal_c) begin
            state_d = FAULT;
            fault_d = 1'b1;
          end else if (fetch_en_c) begin
            pc_d = pc_q + 64'd4;
          end
        end
        FAULT:   state_d = FAULT;
        default: state_d = RUN;
      endcase
    end
  end

  // Fetch buffer next value: pop shifts head, push lands behind survivors
  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    if (br_valid) begin
      cnt_d = '0;
    end else begin
      if (pop_c) buf_d[0] = buf_q[1];
      if (fetch_en_c) buf_d[wr_pos_c[0]] = '{pc: pc_q, instr: imem_instr};
      cnt_d = cnt_q - CNT_W'(pop_c) + CNT_W'(fetch_en_c);
    end
  end

  // Fetch buffer storage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_q <= '0;
      cnt_q <= '0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef IMEM_FETCH_PERF_EN
  logic stall_c;
  assign stall_c = (state_q == RUN) & (cnt_q == 2'd2) & ~pop_c & ~br_valid;

  // Saturating performance counters, untouched by redirects
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetches <= '0;
      perf_stalls  <= '0;
    end else begin
      if (fetch_en_c && (perf_fetches != 32'hFFFF_FFFF))
        perf_fetches <= perf_fetches + 32'd1;
      if (stall_c && (perf_stalls != 32'hFFFF_FFFF))
        perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl against a queue-based fetch model.
module tb_imem_fetch_ctrl;

  localparam int unsigned MEM_SIZE = 1024;
  localparam logic [63:0] RESET_PC = 64'd0;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        br_valid = 1'b0;
  logic [63:0] br_target = 64'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        fault;
`ifdef IMEM_FETCH_PERF_EN
  logic [31:0] perf_fetches;
  logic [31:0] perf_stalls;
`endif

  imem_fetch_ctrl #(.MEM_SIZE(MEM_SIZE), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset_n(reset_n), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .br_valid(br_valid), .br_target(br_target), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc), .fault(fault)
`ifdef IMEM_FETCH_PERF_EN
    , .perf_fetches(perf_fetches), .perf_stalls(perf_stalls)
`endif
  );

  always #5 clk = ~clk;

  // ROM contents: a fixed hash of the byte address
  function automatic logic [31:0] rom(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction
  assign imem_instr = rom(imem_addr);

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: queue of buffered PCs, PC, stopped flag, counters
  logic [63:0] mq[$];
  logic [63:0] mpc;
  bit          mfault;
  int unsigned mfetch, mstall;
  logic        exp_valid, exp_fault;
  logic [63:0] exp_addr, exp_pc;

  task automatic model_reset();
    mq.delete();
    mpc = RESET_PC; mfault = 1'b0; mfetch = 0; mstall = 0;
  endtask

  // Apply inputs just after the edge, then form expectations mid-cycle
  task automatic drive(input logic br, input logic [63:0] tgt, input logic rdy);
    br_valid = br; br_target = tgt; out_ready = rdy;
    #5;
    exp_valid = (mq.size() > 0) && !br;
    exp_pc    = exp_valid ? mq[0] : 64'd0;
    exp_fault = mfault;
    exp_addr  = mpc;
  endtask

  // Apply the cycle's effect to the model, then move past the next edge
  task automatic advance();
    bit pop, legal, full;
    if (br_valid) begin
      mq.delete(); mpc = br_target; mfault = 1'b0;
    end else begin
      pop   = exp_valid && out_ready;
      legal = (mpc % 4 == 0) && (mpc < 64'(MEM_SIZE - 3));
      full  = (mq.size() == 2);
      if (!mfault && full && !pop) mstall++;
      if (pop) void'(mq.pop_front());
      if (!mfault && legal && (!full || pop)) begin
        mq.push_back(mpc); mpc = mpc + 64'd4; mfetch++;
      end else if (!mfault && !legal) begin
        mfault = 1'b1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0; br_valid = 1'b0; out_ready = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({out_valid, fault, imem_addr, out_pc, out_instr} !== {1'b0, 1'b0, RESET_PC, 64'd0, 32'd0}) begin
      n_bad++;
      $display("FAIL reset: got v=%0b f=%0b addr=%h pc=%h instr=%h want 0 0 %h 0 0",
               out_valid, fault, imem_addr, out_pc, out_instr, RESET_PC);
    end
    apply_reset();
  endtask

  task automatic test_stream();
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 64'd0, 1'b1);
      n_cmp++;
      if ({out_valid, fault, imem_addr} !== {exp_valid, exp_fault, exp_addr}) begin
        n_bad++;
        $display("FAIL stream_ctl cyc %0d: got v=%0b f=%0b addr=%h want v=%0b f=%0b addr=%h",
                 i, out_valid, fault, imem_addr, exp_valid, exp_fault, exp_addr);
      end
      if (i >= 1) begin
        n_cmp++;
        if ({out_valid, out_pc, out_instr} !== {1'b1, 64'(4 * (i - 1)), rom(64'(4 * (i - 1)))}) begin
          n_bad++;
          $display("FAIL stream_seq cyc %0d: got v=%0b pc=%h instr=%h want pc=%h", i, out_valid,
                   out_pc, out_instr, 64'(4 * (i - 1)));
        end
      end
      advance();
    end
  endtask

  task automatic test_stall();
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 64'd0, i >= 6);
      if (i == 5) begin
        n_cmp++;
        if (imem_addr !== 64'd8) begin
          n_bad++; $display("FAIL stall_hold: got addr=%h want 8", imem_addr);
        end
      end
      n_cmp++;
      if ({out_valid, fault, imem_addr} !== {exp_valid, exp_fault, exp_addr}) begin
        n_bad++;
        $display("FAIL stall_ctl cyc %0d: got v=%0b f=%0b addr=%h want v=%0b f=%0b addr=%h",
                 i, out_valid, fault, imem_addr, exp_valid, exp_fault, exp_addr);
      end
      if (exp_valid) begin
        n_cmp++;
        if ({out_pc, out_instr} !== {exp_pc, rom(exp_pc)}) begin
          n_bad++;
          $display("FAIL stall_data cyc %0d: got pc=%h instr=%h want pc=%h instr=%h",
                   i, out_pc, out_instr, exp_pc, rom(exp_pc));
        end
      end
      advance();
    end
  endtask

  // Run a list of (br, target, ready) cycles with full model comparison
  task automatic run_cycles(input string tag, input int n, input logic br0,
                            input logic [63:0] tgt0, input logic rdy);
    for (int i = 0; i < n; i++) begin
      drive(i == 0 ? br0 : 1'b0, tgt0, rdy);
      n_cmp++;
      if ({out_valid, fault, imem_addr} !== {exp_valid, exp_fault, exp_addr}) begin
        n_bad++;
        $display("FAIL %s_ctl cyc %0d: got v=%0b f=%0b addr=%h want v=%0b f=%0b addr=%h",
                 tag, i, out_valid, fault, imem_addr, exp_valid, exp_fault, exp_addr);
      end
      if (exp_valid) begin
        n_cmp++;
        if ({out_pc, out_instr} !== {exp_pc, rom(exp_pc)}) begin
          n_bad++;
          $display("FAIL %s_data cyc %0d: got pc=%h instr=%h want pc=%h instr=%h",
                   tag, i, out_pc, out_instr, exp_pc, rom(exp_pc));
        end
      end
      advance();
    end
  endtask

  task automatic test_redirect();
    apply_reset();
    run_cycles("fill", 3, 1'b0, 64'd0, 1'b0);
    drive(1'b1, 64'h40, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL redirect_kill: got v=%0b want 0", out_valid);
    end
    advance();
    n_cmp++;
    if (imem_addr !== 64'h40) begin
      n_bad++; $display("FAIL redirect_addr: got addr=%h want 40", imem_addr);
    end
    run_cycles("redir", 5, 1'b0, 64'd0, 1'b1);
  endtask

  task automatic test_boundary();
    run_cycles("edge", 7, 1'b1, 64'h3F8, 1'b1);
    n_cmp++;
    if ({fault, out_valid, imem_addr} !== {1'b1, 1'b0, 64'h400}) begin
      n_bad++;
      $display("FAIL edge_fault: got f=%0b v=%0b addr=%h want f=1 v=0 addr=400", fault, out_valid, imem_addr);
    end
    run_cycles("resume", 5, 1'b1, 64'd0, 1'b1);
  endtask

  task automatic test_misaligned();
    run_cycles("misal", 4, 1'b1, 64'h42, 1'b1);
    n_cmp++;
    if ({fault, out_valid, imem_addr} !== {1'b1, 1'b0, 64'h42}) begin
      n_bad++;
      $display("FAIL misal_stop: got f=%0b v=%0b addr=%h want f=1 v=0 addr=42", fault, out_valid, imem_addr);
    end
    run_cycles("wrap", 3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
  endtask

  task automatic test_async_reset();
    apply_reset();
    run_cycles("prestall", 4, 1'b0, 64'd0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, fault, imem_addr} !== {1'b0, 1'b0, RESET_PC}) begin
      n_bad++;
      $display("FAIL async_reset: got v=%0b f=%0b addr=%h want 0 0 %h", out_valid, fault, imem_addr, RESET_PC);
    end
    model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    run_cycles("restart", 5, 1'b0, 64'd0, 1'b1);
  endtask

  task automatic test_random();
    logic [63:0] tgt;
    logic        br;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      br = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0: tgt = 64'($urandom_range(0, 255)) * 64'd4;
        1: tgt = 64'h3E8 + 64'($urandom_range(0, 6)) * 64'd4;
        2: tgt = 64'($urandom_range(0, 1023));
        default: tgt = {32'($urandom), 32'($urandom)};
      endcase
      drive(br, tgt, $urandom_range(0, 3) != 0);
      n_cmp++;
      if ({out_valid, fault, imem_addr} !== {exp_valid, exp_fault, exp_addr}) begin
        n_bad++;
        $display("FAIL rand_ctl cyc %0d: got v=%0b f=%0b addr=%h want v=%0b f=%0b addr=%h",
                 i, out_valid, fault, imem_addr, exp_valid, exp_fault, exp_addr);
      end
      if (exp_valid) begin
        n_cmp++;
        if ({out_pc, out_instr} !== {exp_pc, rom(exp_pc)}) begin
          n_bad++;
          $display("FAIL rand_data cyc %0d: got pc=%h instr=%h want pc=%h", i, out_pc, out_instr, exp_pc);
        end
      end
      advance();
    end
`ifdef IMEM_FETCH_PERF_EN
    n_cmp++;
    if ({perf_fetches, perf_stalls} !== {32'(mfetch), 32'(mstall)}) begin
      n_bad++;
      $display("FAIL rand_perf: got fetches=%0d stalls=%0d want %0d %0d", perf_fetches, perf_stalls, mfetch, mstall);
    end
`endif
  endtask

`ifdef IMEM_FETCH_PERF_EN
  task automatic test_perf();
    apply_reset();
    run_cycles("perf_run", 10, 1'b0, 64'd0, 1'b1);
    run_cycles("perf_stall", 4, 1'b0, 64'd0, 1'b0);
    n_cmp++;
    if ({perf_fetches, perf_stalls} !== {32'(mfetch), 32'(mstall)}) begin
      n_bad++;
      $display("FAIL perf: got fetches=%0d stalls=%0d want %0d %0d", perf_fetches, perf_stalls, mfetch, mstall);
    end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_boundary();
    test_misaligned();
    test_async_reset();
    test_random();
`ifdef IMEM_FETCH_PERF_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
- Fetch sequencer for the combinational instruction ROM.
- Owns the program counter and drives the ROM byte address.
- Captures each returned 32-bit instruction with its PC into a 2-entry fetch buffer, which feeds the IF/ID stage over a valid/ready handshake.
- Handles branch redirects (flush plus new PC) and fault-stops on misaligned or out-of-range fetch addresses, so the ROM never sees an illegal access.

Parameters:
- MEM_SIZE, 1024: ROM size in bytes; power of two, greater than 4.
- RESET_PC, 0: PC loaded on reset; word-aligned.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- imem_addr  output  64  byte address to the ROM; equals pc combinationally.
- imem_instr  input  32  instruction returned combinationally by the ROM for imem_addr.
- br_valid  input  1  redirect request, single-cycle.
- br_target  input  64  redirect byte address.
- out_valid  output  1  head of fetch buffer is valid.
- out_ready  input  1  downstream accepts the head.
- out_instr  output  32  head instruction.
- out_pc  output  64  head PC.
- fault  output  1  sticky flag: fetch stopped on an illegal address.

Behaviour:
- Reset (reset_n=0, takes effect immediately, including mid-operation):
  - pc=RESET_PC, buffer count=0, state=RUN.
  - out_valid=0, out_instr=0, out_pc=0, fault=0.
- States:
  - RUN: fetching.
  - FAULT: fetching stopped.
- Legal fetch address: pc[1:0]==0 and pc+3 < MEM_SIZE, using 64-bit unsigned compare with no wrap.
- pop = out_valid & out_ready.
- fetch_en = (state==RUN) & legal & ~br_valid & (count<2 | pop).
- On fetch_en:
  - push {pc, imem_instr} at the buffer tail.
  - pc <= pc+4.
- In RUN with ~br_valid and the address illegal:
  - go to FAULT and set fault=1.
  - no push; pc holds.
- In FAULT, buffered entries still drain normally; pc and imem_addr hold.
- Redirect (br_valid=1, in any state):
  - buffer count <= 0.
  - pc <= br_target.
  - state <= RUN and fault <= 0.
  - the legality check applies to br_target on the next cycle.
  - out_valid is forced to 0 in the br_valid cycle, so no transfer occurs.
  - Redirect has priority over fetch, pop and fault entry.
- Buffer and output timing:
  - out_* present the oldest entry; out_valid = (count>0) & ~br_valid.
  - out_instr and out_pc show the head entry when out_valid=1; their value while out_valid=0 is don't-care, except at reset.
  - Latency: an instruction fetched in cycle N is presented on out_* in cycle N+1.
- Simultaneous push and pop: count unchanged and ordering preserved.
- Full buffer (count=2) with pop: fetch proceeds in the same cycle, giving a sustained 1 instruction/cycle.
- Full buffer without pop: no fetch; pc and imem_addr hold.
- Arithmetic: pc+4 is 64-bit and may exceed MEM_SIZE; the legality check catches this on the next cycle.

Optional Feature:
- Macro: IMEM_FETCH_PERF_EN.
- When defined:
  - add outputs perf_fetches (32) and perf_stalls (32).
  - perf_fetches increments on each fetch_en.
  - perf_stalls increments each cycle that state==RUN & count==2 & ~pop & ~br_valid.
  - both counters saturate at 0xFFFFFFFF and reset to 0; redirects do not clear them.
- When undefined: these ports and this logic are absent; all other behaviour is identical.

Test Plan:
- Release reset with out_ready=1 -> out_valid=1 from the first cycle after release; out_pc=0,4,8,12 on consecutive cycles; out_instr matches the ROM words; fault=0.
- Hold out_ready=0 for 6 cycles after reset -> count reaches 2 (entries 0,4); imem_addr holds at 8. Then raise out_ready -> out_pc sequence 0,4,8,12 with no gaps or duplicates.
- With 2 entries buffered, pulse br_valid with br_target=0x40 -> out_valid=0 in that cycle; next cycle imem_addr=0x40; the cycle after, out_pc=0x40; old entries are never delivered.
- Run sequentially from RESET_PC=0x3F8 (MEM_SIZE=1024) -> out_pc 0x3F8, 0x3FC delivered; at pc=0x400 fault=1 and out_valid drops after the drain. Then br_target=0 -> fault=0, and fetch resumes at 0.
- Redirect to br_target=0x42 -> next cycle fault=1 with no push and out_valid=0; imem_addr holds at 0x42.
- Assert reset_n=0 mid-stall with 2 entries buffered -> out_valid=0, fault=0 and imem_addr=RESET_PC immediately, without waiting for clk; after release, fetching restarts at RESET_PC.
- With IMEM_FETCH_PERF_EN, run 10 fetches then stall 3 cycles on a full buffer -> perf_fetches=10, perf_stalls=3.
